// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: imem request/response, redirect from branch
// resolution, and the {inst, pc} handshake towards decode.
interface inst_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output inst_valid,
        output inst,
        output inst_pc,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        output inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: credit-limited word fetches, in-order
// response buffer, redirect flush with in-flight response dropping.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          started;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    logic [CW:0]   credit_used;
    logic [CW-1:0] out_next;
    logic [31:0]   target;
    logic          req_fire;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic          unused_lsb;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Every issued request owns a buffer slot, so pushes never overflow.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req_valid = rst_n && started && !bus.redirect_valid
                             && (credit_used < {1'b0, DEPTH_C});
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_drop = (drop != '0);
    assign push = bus.imem_resp_valid && !resp_drop && !bus.redirect_valid;
    assign pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign out_next = outstanding + CW'(req_fire)
                    - CW'(bus.imem_resp_valid);

    assign target     = {bus.redirect_pc[31:2], 2'b00};
    assign unused_lsb = ^bus.redirect_pc[1:0];

    assign bus.inst_valid = rst_n && (count != '0);
    assign bus.inst    = bus.inst_valid ? fifo_inst[rd_ptr] : 32'h0;
    assign bus.inst_pc = bus.inst_valid ? fifo_pc[rd_ptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            started     <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= out_next;
            if (bus.redirect_valid) begin
                // Whatever is still in flight after this edge is stale.
                fetch_pc <= target;
                resp_pc  <= target;
                drop     <= out_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (bus.imem_resp_valid && resp_drop)
                    drop <= drop - 1'b1;
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= next_ptr(wr_ptr);
                end
                if (pop)
                    rd_ptr <= next_ptr(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.imem_resp_data;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    resp_has_request: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.imem_resp_valid |-> (outstanding != '0)
    );
endmodule
